// File: rtl/denise_sprites_shifter_if.sv
// denise_sprites_shifter_if: register bus and pixel outputs of one sprite shifter.
interface denise_sprites_shifter_if;
    logic        clk7_en;
    logic        aen;
    logic [1:0]  address;
    logic [8:0]  hpos;
    logic [15:0] fmode;
    logic [48:0] chip48;
    logic [15:0] data_in;
    logic [1:0]  sprdata;
    logic        attach;
    modport master (
        output clk7_en, aen, address, hpos, fmode, chip48, data_in,
        input  sprdata, attach
    );
    modport slave (
        input  clk7_en, aen, address, hpos, fmode, chip48, data_in,
        output sprdata, attach
    );
endinterface

// File: rtl/denise_sprites_shifter.sv
// denise_sprites_shifter: one sprite's POS/CTL/DATA/DATB registers and 64-bit pixel shifters.
// Define SPR_WIDE_FETCH_EN for fmode-dependent 16/32/64-bit latch fills.
module denise_sprites_shifter (
    input logic clk,
    input logic reset,
    denise_sprites_shifter_if.slave bus
);
    logic [8:0]  hstart;
    logic        attach_q;
    logic        armed;
    logic [63:0] lat_a, lat_b, sh_a, sh_b, fill;
    logic        load;
    logic        unused;
`ifdef SPR_WIDE_FETCH_EN
    assign fill = &bus.fmode[3:2] ? {bus.data_in, bus.chip48[47:0]}
                : |bus.fmode[3:2] ? {bus.data_in, bus.chip48[47:32], 32'h0}
                : {bus.data_in, 48'h0};
    assign unused = ^{bus.fmode[15:4], bus.fmode[1:0], bus.chip48[48]};
`else
    assign fill = {bus.data_in, 48'h0};
    assign unused = ^{bus.fmode, bus.chip48};
`endif
    // Load compares against pre-write hstart/armed; same-edge writes land afterwards.
    assign load = armed && bus.hpos == hstart;
    always_ff @(posedge clk) begin
        if (reset) begin
            hstart   <= '0;
            attach_q <= 1'b0;
            armed    <= 1'b0;
            lat_a    <= '0;
            lat_b    <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
        end else if (bus.clk7_en) begin
            sh_a <= load ? lat_a : sh_a << 1;
            sh_b <= load ? lat_b : sh_b << 1;
            if (bus.aen) begin
                case (bus.address)
                    2'd0: hstart[8:1] <= bus.data_in[7:0];
                    2'd1: begin
                        hstart[0] <= bus.data_in[0];
                        attach_q  <= bus.data_in[7];
                        armed     <= 1'b0;
                    end
                    2'd2: begin
                        lat_a <= fill;
                        armed <= 1'b1;
                    end
                    default: lat_b <= fill;
                endcase
            end
        end
    end
    assign bus.sprdata = {sh_b[63], sh_a[63]};
    assign bus.attach  = attach_q;
endmodule

// File: tb/tb_denise_sprites_shifter.sv
// tb_denise_sprites_shifter: vector table plus hand sequences, expectations queued per edge.
module tb_denise_sprites_shifter;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;
    denise_sprites_shifter_if bus ();
    denise_sprites_shifter dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        logic        rs, en, aen;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [8:0]  hpos;
        logic [1:0]  spr;
        logic        att;
    } vec_t;
    typedef struct {
        string      name;
        logic [1:0] spr;
        logic       att;
    } exp_t;
    vec_t tbl[$];
    exp_t sb[$];
    function automatic vec_t v(input string nm, input logic rs, en, aen, input logic [1:0] ad,
                               input logic [15:0] d, input logic [8:0] hp, input logic [1:0] es,
                               input logic ea);
        vec_t r;
        r.name = nm; r.rs = rs; r.en = en; r.aen = aen; r.addr = ad;
        r.data = d; r.hpos = hp; r.spr = es; r.att = ea;
        return r;
    endfunction
    task automatic step(input string nm, input logic rs, en, aen, input logic [1:0] ad,
                        input logic [15:0] d, input logic [8:0] hp, input logic [1:0] es,
                        input logic ea);
        exp_t e;
        reset = rs; bus.clk7_en = en; bus.aen = aen; bus.address = ad;
        bus.data_in = d; bus.hpos = hp;
        sb.push_back('{nm, es, ea});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.sprdata !== e.spr || bus.attach !== e.att) begin
            errors++;
            $display("FAIL %s: sprdata=%b attach=%b, expected sprdata=%b attach=%b",
                     e.name, bus.sprdata, bus.attach, e.spr, e.att);
        end
    endtask
    task automatic setup(input logic [15:0] datb, input logic [15:0] data);
        step("pos", 0, 1, 1, 0, 16'h0040, 9'h000, 2'b00, bus.attach);
        step("ctl", 0, 1, 1, 1, 16'h0080, 9'h000, 2'b00, 1);
        step("datb", 0, 1, 1, 3, datb, 9'h000, 2'b00, 1);
        step("data", 0, 1, 1, 2, data, 9'h000, 2'b00, 1);
    endtask
    task automatic pixel15(input string nm);
        for (int i = 0; i < 14; i++) step({nm, "_gap"}, 0, 1, 0, 0, 0, 9'(256 + i), 2'b00, 1);
        step({nm, "_px15"}, 0, 1, 0, 0, 0, 9'h10e, 2'b01, 1);
        step({nm, "_px16"}, 0, 1, 0, 0, 0, 9'h10f, 2'b00, 1);
    endtask
    logic [1:0] exp_px;
    initial begin
        bus.fmode = 16'h0000;
        bus.chip48 = '0;
        tbl.push_back(v("reset", 1, 0, 0, 0, 0, 9'h000, 2'b00, 0));
        tbl.push_back(v("pos", 0, 1, 1, 0, 16'h0040, 9'h000, 2'b00, 0));
        tbl.push_back(v("ctl", 0, 1, 1, 1, 16'h0080, 9'h000, 2'b00, 1));
        tbl.push_back(v("datb", 0, 1, 1, 3, 16'h0000, 9'h000, 2'b00, 1));
        tbl.push_back(v("data", 0, 1, 1, 2, 16'h8001, 9'h000, 2'b00, 1));
        tbl.push_back(v("aen_off", 0, 1, 0, 1, 16'h0000, 9'h07f, 2'b00, 1));
        tbl.push_back(v("load", 0, 1, 0, 0, 0, 9'h080, 2'b01, 1));
        for (int i = 0; i < 14; i++) tbl.push_back(v("gap", 0, 1, 0, 0, 0, 9'(256 + i), 2'b00, 1));
        tbl.push_back(v("px15", 0, 1, 0, 0, 0, 9'h10e, 2'b01, 1));
        tbl.push_back(v("px16", 0, 1, 0, 0, 0, 9'h10f, 2'b00, 1));
        tbl.push_back(v("retrigger", 0, 1, 0, 0, 0, 9'h080, 2'b01, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v("mid", 0, 1, 0, 0, 0, 9'(300 + i), 2'b00, 1));
        tbl.push_back(v("restart", 0, 1, 0, 0, 0, 9'h080, 2'b01, 1));
        for (int i = 0; i < 14; i++) tbl.push_back(v("rgap", 0, 1, 0, 0, 0, 9'(256 + i), 2'b00, 1));
        tbl.push_back(v("rpx15", 0, 1, 0, 0, 0, 9'h10e, 2'b01, 1));
        tbl.push_back(v("sim_old_latch", 0, 1, 1, 2, 16'h4000, 9'h080, 2'b01, 1));
        tbl.push_back(v("sim_shift", 0, 1, 0, 0, 0, 9'h1f0, 2'b00, 1));
        tbl.push_back(v("new_latch", 0, 1, 0, 0, 0, 9'h080, 2'b00, 1));
        tbl.push_back(v("new_px1", 0, 1, 0, 0, 0, 9'h1f1, 2'b01, 1));
        tbl.push_back(v("new_px2", 0, 1, 0, 0, 0, 9'h1f2, 2'b00, 1));
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].rs, tbl[i].en, tbl[i].aen, tbl[i].addr, tbl[i].data,
                 tbl[i].hpos, tbl[i].spr, tbl[i].att);
        // Idle sweep of the beam after reset: nothing armed, nothing shown.
        step("sweep_reset", 1, 1, 0, 0, 0, 9'h000, 2'b00, 0);
        for (int h = 0; h < 512; h++) step("sweep", 0, 1, 0, 0, 0, 9'(h), 2'b00, 0);
        // CTL disarms before the match; DATA rearms.
        setup(16'h0000, 16'h8001);
        step("disarm_ctl", 0, 1, 1, 1, 16'h0080, 9'h07f, 2'b00, 1);
        step("disarm_match", 0, 1, 0, 0, 0, 9'h080, 2'b00, 1);
        step("disarm_after", 0, 1, 0, 0, 0, 9'h081, 2'b00, 1);
        step("rearm_data", 0, 1, 1, 2, 16'h8001, 9'h07f, 2'b00, 1);
        step("rearm_load", 0, 1, 0, 0, 0, 9'h080, 2'b01, 1);
        for (int i = 0; i < 3; i++) step("freeze", 0, 0, 0, 0, 0, 9'h081, 2'b01, 1);
        pixel15("resume");
        // Reset mid-shift, with and without clk7_en.
        step("rst_load", 0, 1, 0, 0, 0, 9'h080, 2'b01, 1);
        step("rst_shift", 0, 1, 0, 0, 0, 9'h081, 2'b00, 1);
        step("rst_en", 1, 1, 0, 0, 0, 9'h082, 2'b00, 0);
        step("rst_pos", 0, 1, 1, 0, 16'h0040, 9'h000, 2'b00, 0);
        step("rst_ctl", 0, 1, 1, 1, 16'h0080, 9'h000, 2'b00, 1);
        step("rst_noload", 0, 1, 0, 0, 0, 9'h080, 2'b00, 1);
        step("rst_data", 0, 1, 1, 2, 16'h8001, 9'h000, 2'b00, 1);
        step("rst_reload", 0, 1, 0, 0, 0, 9'h080, 2'b01, 1);
        step("rst_noen", 1, 0, 0, 0, 0, 9'h081, 2'b00, 0);
        setup(16'h0000, 16'h0000);
        step("rst_noen_noload", 0, 1, 0, 0, 0, 9'h080, 2'b00, 1);
        // 64-bit fill: DATA takes chip48 ones, DATB takes zeros.
        bus.fmode = 16'h000c;
        setup(16'hffff, 16'h0000);
        bus.chip48 = {1'b0, {48{1'b1}}};
        step("wide_data", 0, 1, 1, 2, 16'h0000, 9'h000, 2'b00, 1);
        bus.chip48 = '0;
        for (int p = 0; p < 67; p++) begin
`ifdef SPR_WIDE_FETCH_EN
            exp_px = p < 16 ? 2'b10 : p < 64 ? 2'b01 : 2'b00;
`else
            exp_px = p < 16 ? 2'b10 : 2'b00;
`endif
            step("wide64_px", 0, 1, 0, 0, 0, p == 0 ? 9'h080 : 9'(256 + p), exp_px, 1);
        end
        // 32-bit fill: only chip48[47:32] lands, lower bits dropped.
        bus.fmode = 16'h0008;
        setup(16'h0000, 16'h0000);
        bus.chip48 = 49'h0_0001_ffff_ffff;
        step("wide32_data", 0, 1, 1, 2, 16'h0000, 9'h000, 2'b00, 1);
        bus.chip48 = '0;
        for (int p = 0; p < 64; p++) begin
`ifdef SPR_WIDE_FETCH_EN
            exp_px = p == 31 ? 2'b01 : 2'b00;
`else
            exp_px = 2'b00;
`endif
            step("wide32_px", 0, 1, 0, 0, 0, p == 0 ? 9'h080 : 9'(256 + p), exp_px, 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/denise_sprites_shifter.md
DENISE_SPRITES_SHIFTER -- requirements
Module: denise_sprites_shifter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 clk  in  1  28 MHz system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 clk7_en  in  1  pixel-rate enable; non-reset state updates only on edges where it is 1.
REQ-005 aen  in  1  register select for this sprite.
REQ-006 address  in  2  register index: 0=POS, 1=CTL, 2=DATA, 3=DATB.
REQ-007 hpos  in  9  horizontal beam counter.
REQ-008 fmode  in  16  fetch mode; only bits [3:2] are used.
REQ-009 chip48  in  49  extra fetched sprite data; bits [47:0] used, bit 48 ignored.
REQ-010 data_in  in  16  register write data.
REQ-011 sprdata  out  2  current pixel, {plane B, plane A}.
REQ-012 attach  out  1  attach bit from CTL.

Function
REQ-013 Writes occur on a clk7_en edge with aen=1; with aen=0, no register changes.
REQ-014 POS write SHALL set hstart[8:1]=data_in[7:0].
REQ-015 CTL write SHALL set hstart[0]=data_in[0], attach=data_in[7], and clear armed.
REQ-016 DATA write SHALL load the 64-bit latch A and set armed.
REQ-017 DATB write SHALL load the 64-bit latch B; armed is unchanged.
REQ-018 Latch fill by fmode[3:2]:
- 00: {data_in, 48'h0}.
- 01/10: {data_in, chip48[47:32], 32'h0}.
- 11: {data_in, chip48[47:0]}.
REQ-019 Load condition: clk7_en=1, armed=1 and hpos==hstart, all 9 bits.
- On a load edge, 64-bit shifters A and B SHALL copy latches A and B.
REQ-020 On other clk7_en edges, both shifters SHALL shift left by 1 with zero fill.
REQ-021 sprdata SHALL be combinational {shiftB[63], shiftA[63]}.
- The first pixel is visible right after the load edge.
- sprdata returns to 00 after all 64 bits have shifted out.
REQ-022 armed SHALL stay set after a load, so the sprite retriggers on each hstart match until a CTL write.
- A match while still shifting reloads the shifters and restarts output.
REQ-023 Simultaneous write and load: the load uses the pre-write latch, hstart and armed values; the write takes effect after the edge.
REQ-024 On clk7_en=0 edges, all state SHALL hold.

Reset
REQ-025 reset=1 on any rising clk edge, regardless of clk7_en, SHALL clear the following; reset takes priority over writes, loads and shifts:
- hstart, attach, armed.
- both latches and both shifters.
- so sprdata=00 and attach=0.

Configuration
REQ-026 Macro SPR_WIDE_FETCH_EN.
- Defined: fmode-dependent 16/32/64-bit fill per REQ-018.
- Undefined: latches always filled as {data_in, 48'h0}; fmode and chip48 are ignored.

Verification
REQ-027 Reset, then hold hpos sweep 0..511 -> sprdata=00 and attach=0 throughout.
REQ-028 fmode=0; POS=0x0040; CTL=0x0080; DATB=0x0000; DATA=0x8001.
- Required: attach=1.
- At hpos=0x080: load, sprdata=01.
- Next 14 enabled edges: sprdata=00.
- 16th pixel: sprdata=01, then 00.
REQ-029 Same setup, then CTL write before hpos reaches hstart -> no load, sprdata stays 00.
- A later DATA write rearms the sprite.
REQ-030 SPR_WIDE_FETCH_EN, fmode[3:2]=11, chip48[47:0]=all ones, DATA=0x0000, DATB=0xFFFF, at match:
- Pixels 0-15: sprdata=10.
- Pixels 16-63: sprdata=01.
- Afterwards: sprdata=00.
REQ-031 Toggle clk7_en low for 3 edges mid-shift -> sprdata frozen, then resumes the sequence unchanged.
REQ-032 Assert reset mid-shift -> sprdata=00 on the next edge, and no further loads until a new DATA write.
